// File: rtl/fifo_read_interface_pkg.sv
// fifo_pkg: buffer state type and pointer helpers shared by the read and write sides.
package fifo_pkg;

    typedef enum logic [1:0] {BUF_EMPTY, BUF_ONE, BUF_TWO} buf_state_e;

    function automatic int ptr_w(input int aw);
        return aw + 1;
    endfunction

    function automatic logic ptr_empty(input logic [31:0] wa, input logic [31:0] ra);
        return wa == ra;
    endfunction

    // Pointers are zero-extended, so full means they differ in the wrap bit only.
    function automatic logic ptr_full(input logic [31:0] wa, input logic [31:0] ra, input int aw);
        return (wa ^ ra) == (32'd1 << aw);
    endfunction

endpackage

// File: rtl/fifo_read_interface_if.sv
// fifo_read_interface_if: first-word-fall-through valid/ready consumer port.
interface fifo_read_interface_if #(parameter int DATA_WIDTH = 8);
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;

    modport master(output rd_valid, output rd_data, input rd_ready);
    modport slave(input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/fifo_read_interface_read_pointer.sv
// read_pointer: wrap-bit address counter with increment enable.
module read_pointer import fifo_pkg::*; #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              inc,
    output logic [ADDR_WIDTH:0] ptr
);
    localparam int PW = ptr_w(ADDR_WIDTH);

    logic [PW-1:0] ptr_q, ptr_d;

    always_comb ptr_d = inc ? ptr_q + PW'(1) : ptr_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;
endmodule

// File: rtl/fifo_read_interface.sv
// fifo_read_interface: FIFO read side; owns the read pointer, derives flags and
// hides the memory read latency behind a 2-entry output buffer.
module fifo_read_interface import fifo_pkg::*; #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ADDR_WIDTH:0]   write_addr,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  mem_read_en,
    output logic [ADDR_WIDTH:0]   read_addr,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    fifo_read_interface_if.master rd
);
    buf_state_e            state_q, state_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [1:0]            occ;
    logic                  pop;

    read_pointer #(.ADDR_WIDTH(ADDR_WIDTH)) u_read_pointer (
        .clk (clk),
        .rstn(rstn),
        .inc (mem_read_en),
        .ptr (read_addr)
    );

    assign empty = ptr_empty(32'(write_addr), 32'(read_addr));
    assign full  = ptr_full(32'(write_addr), 32'(read_addr), ADDR_WIDTH);
    assign count = write_addr - read_addr;

    assign occ         = state_q == BUF_TWO ? 2'd2 : state_q == BUF_ONE ? 2'd1 : 2'd0;
    assign pop         = rd.rd_valid && rd.rd_ready;
    // Fetch only when the word would still have a buffer slot on arrival.
    assign mem_read_en = !empty && ({1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop} < 3'd2);

    assign rd.rd_valid = state_q != BUF_EMPTY;
    assign rd.rd_data  = head_q;

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        inflight_d = mem_read_en;
        unique case (state_q)
            BUF_EMPTY: begin
                state_d = inflight_q ? BUF_ONE : BUF_EMPTY;
                head_d  = inflight_q ? mem_read_data : head_q;
            end
            BUF_ONE: begin
                state_d = inflight_q ? (pop ? BUF_ONE : BUF_TWO) : (pop ? BUF_EMPTY : BUF_ONE);
                head_d  = inflight_q && pop ? mem_read_data : head_q;
                tail_d  = inflight_q && !pop ? mem_read_data : tail_q;
            end
            BUF_TWO: begin
                state_d = pop && !inflight_q ? BUF_ONE : BUF_TWO;
                head_d  = pop ? tail_q : head_q;
                tail_d  = pop && inflight_q ? mem_read_data : tail_q;
            end
            default: state_d = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= BUF_EMPTY;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end
endmodule

// File: tb/tb_fifo_read_interface.sv
// tb_fifo_read_interface: random and directed stimulus against a queue model of FIFO order.
module tb_fifo_read_interface;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [2:0] write_addr;
    logic [7:0] mem_read_data;
    logic       mem_read_en;
    logic [2:0] read_addr;
    logic       full, empty;
    logic [2:0] count;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] mem [4];
    logic [7:0] q [$];
    int         checks = 0, errors = 0, en_cnt = 0, npop = 0;
    logic       wrapped = 1'b0;

    always #5 clk = ~clk;

    fifo_read_interface_if #(.DATA_WIDTH(8)) bus ();

    fifo_read_interface #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .write_addr   (write_addr),
        .mem_read_data(mem_read_data),
        .mem_read_en  (mem_read_en),
        .read_addr    (read_addr),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .rd           (bus)
    );

    // Write side and memory with one cycle of read latency.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            write_addr    <= 3'd0;
            mem_read_data <= 8'h00;
        end else begin
            if (wr_en && !full) begin
                mem[write_addr[1:0]] <= wr_data;
                write_addr           <= write_addr + 3'd1;
            end
            if (mem_read_en) mem_read_data <= mem[read_addr[1:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic we, input logic [7:0] wd, input logic rr, output logic acc);
        logic       stall;
        logic [7:0] hold;
        logic [2:0] ra;
        wr_en = we;
        wr_data = wd;
        bus.rd_ready = rr;
        #1;
        if (bus.rd_valid && rr) begin
            npop++;
            if (q.size() == 0) chk("pop_unexpected", 32'(1), 32'(0));
            else chk("pop_data", 32'(bus.rd_data), 32'(q.pop_front()));
        end
        acc = we && !full;
        if (acc) q.push_back(wd);
        if (mem_read_en) en_cnt++;
        stall = bus.rd_valid && !rr;
        hold = bus.rd_data;
        ra = read_addr;
        @(negedge clk);
        if (ra == 3'd7 && read_addr == 3'd0) wrapped = 1'b1;
        if (stall) begin
            chk("stall_valid", 32'(bus.rd_valid), 32'(1));
            chk("stall_data", 32'(bus.rd_data), 32'(hold));
        end
    endtask

    task automatic idle(input int n, input logic rr);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, rr, acc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic       acc, tog;
        logic [7:0] d;
        int         sent, guard, pops_before;
        bus.rd_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_empty", 32'(empty), 32'(1));
        chk("rst_full", 32'(full), 32'(0));
        chk("rst_count", 32'(count), 32'(0));
        chk("rst_valid", 32'(bus.rd_valid), 32'(0));
        chk("rst_rd_en", 32'(mem_read_en), 32'(0));
        chk("rst_raddr", 32'(read_addr), 32'(0));
        rstn = 1'b1;
        @(negedge clk);

        en_cnt = 0;
        step(1'b1, 8'hA5, 1'b0, acc);
        chk("one_rd_en", 32'(mem_read_en), 32'(1));
        chk("one_valid_n", 32'(bus.rd_valid), 32'(0));
        idle(1, 1'b0);
        chk("one_valid_n1", 32'(bus.rd_valid), 32'(0));
        chk("one_raddr", 32'(read_addr), 32'(1));
        idle(1, 1'b0);
        chk("one_valid", 32'(bus.rd_valid), 32'(1));
        chk("one_data", 32'(bus.rd_data), 32'(8'hA5));
        chk("one_empty", 32'(empty), 32'(1));
        chk("one_count", 32'(count), 32'(0));
        chk("one_en_cnt", 32'(en_cnt), 32'(1));
        idle(1, 1'b1);

        for (int i = 1; i <= 6; i++) step(1'b1, 8'(i), 1'b0, acc);
        en_cnt = 0;
        idle(2, 1'b0);
        step(1'b1, 8'hEE, 1'b0, acc);
        chk("fill_reject", 32'(acc), 32'(0));
        chk("fill_full", 32'(full), 32'(1));
        chk("fill_count", 32'(count), 32'(4));
        chk("fill_raddr", 32'(read_addr), 32'(3));
        chk("fill_head", 32'(bus.rd_data), 32'(8'h01));
        chk("fill_no_fetch", 32'(en_cnt), 32'(0));

        for (int i = 1; i <= 6; i++) begin
            idle(1, 1'b1);
            if (i == 1) begin
                chk("drain_full", 32'(full), 32'(0));
                chk("drain_count", 32'(count), 32'(3));
            end
            if (i < 6) chk("drain_no_bubble", 32'(bus.rd_valid), 32'(1));
        end
        chk("drain_empty", 32'(empty), 32'(1));
        chk("drain_valid", 32'(bus.rd_valid), 32'(0));
        chk("drain_q", 32'(q.size()), 32'(0));

        wrapped = 1'b0;
        tog = 1'b0;
        sent = 0;
        guard = 0;
        d = 8'($urandom);
        while (sent < 20 && guard < 500) begin
            step(1'b1, d, tog, acc);
            tog = ~tog;
            guard++;
            if (acc) begin
                sent++;
                d = 8'($urandom);
            end
        end
        chk("stream_sent", 32'(sent), 32'(20));
        guard = 0;
        while (q.size() > 0 && guard < 200) begin
            idle(1, tog);
            tog = ~tog;
            guard++;
        end
        idle(3, 1'b1);
        chk("stream_drained", 32'(q.size()), 32'(0));
        chk("stream_wrap", 32'(wrapped), 32'(1));
        chk("stream_raddr", 32'(read_addr), 32'(3));
        chk("stream_valid", 32'(bus.rd_valid), 32'(0));

        for (int i = 0; i < 150; i++) step(1'($urandom), 8'($urandom), 1'($urandom), acc);
        guard = 0;
        while (q.size() > 0 && guard < 200) begin
            idle(1, 1'b1);
            guard++;
        end
        idle(3, 1'b1);
        chk("rand_drained", 32'(q.size()), 32'(0));
        chk("rand_empty", 32'(empty), 32'(1));
        chk("rand_valid", 32'(bus.rd_valid), 32'(0));

        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h40 + i), 1'b0, acc);
        chk("pre_rst_full", 32'(full), 32'(1));
        #2 rstn = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.rd_valid), 32'(0));
        chk("arst_raddr", 32'(read_addr), 32'(0));
        chk("arst_rd_en", 32'(mem_read_en), 32'(0));
        chk("arst_empty", 32'(empty), 32'(1));
        q.delete();
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle(1, 1'b1);
            chk("post_rst_idle", 32'(bus.rd_valid), 32'(0));
        end
        step(1'b1, 8'h3C, 1'b0, acc);
        idle(3, 1'b0);
        pops_before = npop;
        idle(2, 1'b1);
        chk("post_rst_pops", 32'(npop - pops_before), 32'(1));
        chk("post_rst_q", 32'(q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
